// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a single-port word RAM.
// Sub-word stores become a read-modify-write pair; loads are lane-extracted and extended.
module mem_access_unit #(
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             ram_ena,
  output logic             ram_wena,
  output logic [DEPTH-1:0] ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR} state_t;

  state_t           r_state;
  logic             r_ready;
  logic [DEPTH-1:0] r_addr;
  logic [1:0]       r_off;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [31:0]      r_wdata;
  logic [31:0]      r_merge;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [31:0]      r_resp_rdata;

  logic             w_accept;
  logic             w_misaligned;
  logic [4:0]       w_shift;
  logic [7:0]       w_lane_b;
  logic [15:0]      w_lane_h;
  logic [31:0]      w_load_data;
  logic [31:0]      w_byte_mask;
  logic [31:0]      w_merged;
  logic             w_unused;

  // Upper address bits are don't-care: the RAM address wraps.
  assign w_unused = ^req_addr[31:DEPTH+2];

  assign w_accept = req_valid && r_ready;

  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  // Big-endian lanes: offset 0 sits in the top byte, so shift by (3 - off) bytes.
  assign w_shift  = {~r_off, 3'b000};
  assign w_lane_b = 8'(ram_rdata >> w_shift);
  assign w_lane_h = r_off[1] ? ram_rdata[15:0] : ram_rdata[31:16];

  always_comb begin
    w_load_data = ram_rdata;
    case (r_size)
      2'b00:   w_load_data = r_uns ? {24'b0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
      2'b01:   w_load_data = r_uns ? {16'b0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
      default: w_load_data = ram_rdata;
    endcase
  end

  assign w_byte_mask = 32'h0000_00FF << w_shift;

  always_comb begin
    w_merged = r_merge;
    if (r_size == 2'b00)
      w_merged = (r_merge & ~w_byte_mask) | (32'(r_wdata[7:0]) << w_shift);
    else if (r_off[1])
      w_merged = {r_merge[31:16], r_wdata[15:0]};
    else
      w_merged = {r_wdata[15:0], r_merge[15:0]};
  end

  // RAM side is decoded from state so that reset drops it immediately.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wena  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (r_state)
      S_LOAD, S_RMW_RD: begin
        ram_ena  = 1'b1;
        ram_addr = r_addr;
      end
      S_STORE: begin
        ram_ena   = 1'b1;
        ram_wena  = 1'b1;
        ram_addr  = r_addr;
        ram_wdata = r_wdata;
      end
      S_RMW_WR: begin
        ram_ena   = 1'b1;
        ram_wena  = 1'b1;
        ram_addr  = r_addr;
        ram_wdata = w_merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_addr       <= '0;
      r_off        <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_wdata      <= '0;
      r_merge      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr[DEPTH+1:2];
            r_off   <= req_addr[1:0];
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
            if (w_misaligned) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_ready <= 1'b0;
              if (!req_we)
                r_state <= S_LOAD;
              else if (req_size == 2'b10)
                r_state <= S_STORE;
              else
                r_state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
        end
        S_RMW_RD: begin
          r_merge <= ram_rdata;
          r_state <= S_RMW_WR;
        end
        S_STORE, S_RMW_WR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word RAM attached.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_ena;
  logic        ram_wena;
  logic [2:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        mem_clr;
  logic [31:0] mem [8];

  int n_run  = 0;
  int n_fail = 0;

  mem_access_unit #(.DEPTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_ena      (ram_ena),
    .ram_wena     (ram_wena),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (ram_ena && ram_wena) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = data;
  endtask

  // Issues a load, checks the RAM read in cycle 1 and the response in cycle 2.
  task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, size, uns, addr, 32'h0);
    cyc();
    req_valid = 1'b0;
    check({tag, "_ena"}, 32'(ram_ena), 32'd1);
    check({tag, "_wena"}, 32'(ram_wena), 32'd0);
    cyc();
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Misaligned request: error response in cycle 1, RAM untouched.
  task automatic mis_chk(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr);
    issue(we, size, 1'b0, addr, 32'h1234_5678);
    cyc();
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd1);
    check({tag, "_rdata"}, resp_rdata, 32'h0);
    check({tag, "_ena"}, 32'(ram_ena), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    cyc();
    cyc();

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_ena", 32'(ram_ena), 32'd0);
    check("rst_wena", 32'(ram_wena), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", ram_wdata, 32'h0);
    rst = 1'b0;
    mem_clr = 1'b0;

    // sw 0x8 <- 0xDEADBEEF
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
    cyc();
    req_valid = 1'b0;
    check("sw_ena", 32'(ram_ena), 32'd1);
    check("sw_wena", 32'(ram_wena), 32'd1);
    check("sw_addr", 32'(ram_addr), 32'd2);
    check("sw_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("sw_busy", 32'(req_ready), 32'd0);
    check("sw_c1_valid", 32'(resp_valid), 32'd0);
    cyc();
    check("sw_valid", 32'(resp_valid), 32'd1);
    check("sw_err", 32'(resp_err), 32'd0);
    check("sw_mem", mem[2], 32'hDEAD_BEEF);

    // Back-to-back loads: each is issued in the response cycle of the previous.
    load_chk("lb", 2'b00, 1'b0, 32'h9, 32'hFFFF_FFAD);
    load_chk("lbu", 2'b00, 1'b1, 32'h9, 32'h0000_00AD);
    load_chk("lh", 2'b01, 1'b0, 32'hA, 32'hFFFF_BEEF);
    load_chk("lhu", 2'b01, 1'b1, 32'hA, 32'h0000_BEEF);
    load_chk("lw", 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
    cyc();
    check("hold_valid", 32'(resp_valid), 32'd0);
    check("hold_rdata", resp_rdata, 32'hDEAD_BEEF);

    // sb 0xB <- 0x12 with a held lw that must wait until the store completes.
    issue(1'b1, 2'b00, 1'b0, 32'hB, 32'hFFFF_FF12);
    cyc();
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    check("sb_c1_ena", 32'(ram_ena), 32'd1);
    check("sb_c1_wena", 32'(ram_wena), 32'd0);
    check("sb_c1_addr", 32'(ram_addr), 32'd2);
    check("sb_c1_ready", 32'(req_ready), 32'd0);
    cyc();
    check("sb_c2_wena", 32'(ram_wena), 32'd1);
    check("sb_c2_wdata", ram_wdata, 32'hDEAD_BE12);
    check("sb_c2_ready", 32'(req_ready), 32'd0);
    check("sb_c2_valid", 32'(resp_valid), 32'd0);
    cyc();
    check("sb_valid", 32'(resp_valid), 32'd1);
    check("sb_rdata", resp_rdata, 32'h0);
    check("sb_ready", 32'(req_ready), 32'd1);
    check("sb_mem", mem[2], 32'hDEAD_BE12);
    cyc();
    req_valid = 1'b0;
    check("lw_after_sb_ena", 32'(ram_ena), 32'd1);
    cyc();
    check("lw_after_sb_valid", 32'(resp_valid), 32'd1);
    check("lw_after_sb_rdata", resp_rdata, 32'hDEAD_BE12);

    // sh 0x8 <- 0x5678 replaces the upper half.
    issue(1'b1, 2'b01, 1'b0, 32'h8, 32'hAAAA_5678);
    cyc();
    req_valid = 1'b0;
    cyc();
    check("sh_wdata", ram_wdata, 32'h5678_BE12);
    cyc();
    check("sh_valid", 32'(resp_valid), 32'd1);
    load_chk("lw_after_sh", 2'b10, 1'b0, 32'h8, 32'h5678_BE12);

    mis_chk("mis_lw6", 1'b0, 2'b10, 32'h6);
    mis_chk("mis_sh3", 1'b1, 2'b01, 32'h3);
    mis_chk("mis_sz3", 1'b0, 2'b11, 32'h0);
    cyc();
    check("mis_after_valid", 32'(resp_valid), 32'd0);
    check("mis_after_ena", 32'(ram_ena), 32'd0);
    check("mis_mem0", mem[0], 32'h0);

    // Address 0x20 wraps onto word 0.
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
    cyc();
    req_valid = 1'b0;
    check("wrap_addr", 32'(ram_addr), 32'd0);
    cyc();
    check("wrap_sw_valid", 32'(resp_valid), 32'd1);
    load_chk("wrap_lw", 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D);

    // Reset during cycle 1 of a word store to word 1.
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h1111_1111);
    cyc();
    req_valid = 1'b0;
    check("rmid_pre_ena", 32'(ram_ena), 32'd1);
    rst = 1'b1;
    #1;
    check("rmid_ena", 32'(ram_ena), 32'd0);
    check("rmid_wena", 32'(ram_wena), 32'd0);
    check("rmid_ready", 32'(req_ready), 32'd1);
    check("rmid_valid", 32'(resp_valid), 32'd0);
    check("rmid_rdata", resp_rdata, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    check("rmid_mem1", mem[1], 32'h0);
    check("rmid_post_valid", 32'(resp_valid), 32'd0);
    check("rmid_post_ena", 32'(ram_ena), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the MEM stage of the pipeline and the single-port word RAM (`ram`, sync write, combinational read). It accepts one load or store request at a time, splits byte and halfword stores into a read-modify-write pair of RAM cycles, extracts and sign- or zero-extends load data, and returns a registered, one-cycle response. Misaligned accesses are rejected without touching the RAM.

## Interface
- `DEPTH`, 3, word-address bits of the attached RAM; RAM word width is fixed at 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; a request is accepted on a rising edge where `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned.
- `req_unsigned`  in  1  zero-extend loads (lbu/lhu); ignored for stores and words.
- `req_addr`  in  32  byte address; bits above DEPTH+1 are ignored (address wraps).
- `req_wdata`  in  32  store data, right-justified for byte and half.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  misaligned request; valid only with `resp_valid`.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors; held between responses.
- `ram_ena`, `ram_wena`  out  1  RAM enable / write enable.
- `ram_addr`  out  DEPTH  word address = latched `req_addr[DEPTH+1:2]`.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM combinational read data.

## Operation
- Byte order is big-endian: byte offset 0 is bits [31:24], offset 3 is [7:0]; half offset 0 is [31:16], offset 2 is [15:0].
- Alignment: half requires `addr[0]==0`; word requires `addr[1:0]==0`; size 11 is always an error.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
  - IDLE: `req_ready=1`. On accept, latch address, size, unsigned flag and wdata.
    - Misaligned: stay in IDLE and assert `resp_valid=1`, `resp_err=1`, `resp_rdata=0` next cycle.
    - Load: go to LOAD.
    - Word store: go to STORE.
    - Byte or half store: go to RMW_RD.
  - LOAD: drive `ram_ena=1`, `ram_wena=0`. At the edge, capture the extended lane into `resp_rdata`, pulse `resp_valid`, and return to IDLE.
  - STORE: drive `ram_ena=1`, `ram_wena=1`, `ram_wdata=wdata`. At the edge, pulse `resp_valid` and return to IDLE.
  - RMW_RD: drive `ram_ena=1`, `ram_wena=0`. At the edge, register `ram_rdata` into the merge register and go to RMW_WR.
  - RMW_WR: drive `ram_ena=1`, `ram_wena=1`, `ram_wdata` = merge register with the addressed lane replaced by the low byte or half of wdata. At the edge, pulse `resp_valid` and return to IDLE.
- RAM-side outputs are combinational from state and latched registers. In IDLE, all RAM outputs are 0.
- `req_valid` while not ready is ignored. The requester holds the request until it is accepted.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, merge register 0, `ram_ena=0`, `ram_wena=0`, `ram_addr=0`, `ram_wdata=0`.
- Request accepted at edge E0 (cycle 0). `resp_valid` is high during:
  - error: cycle 1;
  - load or word store: cycle 2;
  - byte or half store: cycle 3.
- RAM access occurs in cycle 1; RMW stores also access the RAM in cycle 2.
- `req_ready` returns high in the same cycle `resp_valid` is high, so back-to-back requests are accepted then. Throughput is one load per 2 cycles.
- Reset mid-operation: the FSM returns to IDLE and `ram_ena`/`ram_wena` drop immediately. No RAM write happens on any edge while `rst=1`, and no response is issued for the aborted request.

## Test plan
- Reset: assert `rst` during cycle 1 of a word store -> `ram_ena=0` at once, `req_ready=1`, `resp_valid` and `resp_rdata` are 0, and the target word is unchanged.
- Word store: sw addr 0x8, data 0xDEADBEEF -> cycle 1 shows `ram_ena=1`, `ram_wena=1`, `ram_addr=2`, `ram_wdata=0xDEADBEEF`; `resp_valid=1`, `resp_err=0` in cycle 2.
- Loads from word 2 = 0xDEADBEEF:
  - lb 0x9 -> 0xFFFFFFAD; lbu 0x9 -> 0x000000AD;
  - lh 0xA -> 0xFFFFBEEF; lhu 0xA -> 0x0000BEEF;
  - lw 0x8 -> 0xDEADBEEF;
  - each with `resp_valid` in cycle 2.
- Byte store: sb 0xB, data 0x12 on 0xDEADBEEF -> read in cycle 1, then write 0xDEADBE12 in cycle 2, `resp_valid` in cycle 3. `req_valid` held through cycles 1-2 is not accepted. A following lw 0x8 returns 0xDEADBE12.
- Misaligned: lw 0x6, sh 0x3, and size 11 at 0x0 -> `resp_valid=1`, `resp_err=1`, `resp_rdata=0` in cycle 1, and `ram_ena` never asserts.
- Wrap: with DEPTH=3, sw to 0x20 then lw 0x0 -> the load returns the stored data.
